// File: rtl/laplace_stream_filter_pkg.sv
// laplace_stream_filter_pkg
// Shared defaults for the streaming Laplacian filter. It also holds the rule that
// gives the internal arithmetic width from the pixel width. Four extra bits cover
// the range 4*(2^DATA_W-1) down to -4*(2^DATA_W-1) plus a sign bit.
package laplace_stream_filter_pkg;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_IMG_W    = 640;
  localparam int DEFAULT_APPROX_K = 2;
  localparam int INT_W_MARGIN     = 4;

  function automatic int int_width(input int data_w);
    return data_w + INT_W_MARGIN;
  endfunction

  localparam int DEFAULT_INT_W = int_width(DEFAULT_DATA_W);

endpackage

// File: rtl/laplace_line_buffer.sv
// laplace_line_buffer
// Holds one full image line. It has one write port and one read port.
// Ports:
//   clk             : write clock
//   wr_en           : write wr_data at wr_addr on the rising edge
//   wr_addr/wr_data : write column and pixel
//   rd_addr/rd_data : combinational read. It returns the value stored before any
//                     write in the same cycle, so the filter can read a pixel of
//                     the older row and overwrite it in the same cycle.
// The contents are not reset. The filter never uses an entry that has not been
// rewritten since reset or start of frame.
module laplace_line_buffer
  import laplace_stream_filter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IMG_W  = DEFAULT_IMG_W,
  localparam int ADDR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/laplace_stream_filter.sv
// laplace_stream_filter
// Applies a 4-neighbour Laplacian filter to a raster pixel stream. The output
// appears two cycles after each interior source pixel. Border pixels give no output.
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   in_valid     : in_data holds a pixel this cycle
//   in_sof       : start of frame. Valid only with in_valid. The pixel is taken as (0,0).
//   in_data      : unsigned pixel
//   mode_approx  : 1 = approximate neighbour sums (OR the low APPROX_K bits)
//   mode_abs     : 1 = output the magnitude, 0 = clamp negative results to 0
//   out_valid    : out_data is valid this cycle
//   out_data     : saturated Laplacian
//   out_sol      : set on the first output of each interior line
module laplace_stream_filter
  import laplace_stream_filter_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int IMG_W    = DEFAULT_IMG_W,
  parameter int APPROX_K = DEFAULT_APPROX_K
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mode_approx,
  input  logic              mode_abs,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sol
);

  localparam int INT_W = int_width(DATA_W);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = 16;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [ROW_W-1:0] ROW_MAX  = '1;
  localparam logic [INT_W-1:0] LOW_MASK = INT_W'((1 << APPROX_K) - 1);
  localparam logic signed [INT_W-1:0] PIX_MAX = INT_W'((1 << DATA_W) - 1);

  // The exact sum, or an approximate sum. In approximate mode the low bits are the
  // OR of the two operands. No carry leaves the low bits. The upper bits are added exactly.
  function automatic logic [INT_W-1:0] mode_add(input logic [INT_W-1:0] a,
                                                input logic [INT_W-1:0] b,
                                                input logic             approx);
    logic [INT_W-1:0] upper_sum;
    upper_sum = (a & ~LOW_MASK) + (b & ~LOW_MASK);
    return approx ? (upper_sum | ((a | b) & LOW_MASK)) : (a + b);
  endfunction

  logic [COL_W-1:0]  col_q, col_d, pos_col;
  logic [ROW_W-1:0]  row_q, row_d, pos_row;
  logic [DATA_W-1:0] line_a_rd, line_b_rd;
  logic [DATA_W-1:0] h1_q, h1_d, a1_q, a1_d, a2_q, a2_d, b1_q, b1_d;

  logic              s1_valid_q, s1_valid_d, s1_sol_q, s1_sol_d;
  logic              s1_approx_q, s1_approx_d, s1_abs_q, s1_abs_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d, s1_d_q, s1_d_d, s1_e_q, s1_e_d;
  logic [DATA_W-1:0] s1_f_q, s1_f_d, s1_h_q, s1_h_d;

  logic              out_valid_q, out_valid_d, out_sol_q, out_sol_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, result;
  logic [INT_W-1:0]  sum_bd, sum_fh, sum_all;
  logic signed [INT_W-1:0] lap, mag;

  // Line A holds row r-1 and line B holds row r-2. B takes the old entry of A at
  // the same column, so the two lines move down one row together.
  laplace_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_line_a (
    .clk     (clk),
    .wr_en   (in_valid),
    .wr_addr (pos_col),
    .wr_data (in_data),
    .rd_addr (pos_col),
    .rd_data (line_a_rd)
  );

  laplace_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_line_b (
    .clk     (clk),
    .wr_en   (in_valid),
    .wr_addr (pos_col),
    .wr_data (line_a_rd),
    .rd_addr (pos_col),
    .rd_data (line_b_rd)
  );

  // Position of the current pixel. in_sof sets it to (0,0) even in the middle of a frame.
  // row saturates so that very long frames do not wrap back into the border rows.
  always_comb begin
    pos_col = in_sof ? '0 : col_q;
    pos_row = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_MAX) ? pos_row : pos_row + ROW_W'(1);
      end else begin
        col_d = pos_col + COL_W'(1);
        row_d = pos_row;
      end
    end
  end

  // Shift registers that advance on accepted pixels only. At pixel (r,c):
  //   h1=(r,c-1)  a1=(r-1,c-1)  a2=(r-1,c-2)  b1=(r-2,c-1)
  // Together with the line A read (r-1,c) these give the whole window.
  always_comb begin
    h1_d = in_valid ? in_data   : h1_q;
    a1_d = in_valid ? line_a_rd : a1_q;
    a2_d = in_valid ? a1_q      : a2_q;
    b1_d = in_valid ? line_b_rd : b1_q;

    s1_valid_d  = in_valid && (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
    s1_sol_d    = s1_valid_d && (pos_col == COL_TWO);
    s1_b_d      = b1_q;
    s1_d_d      = a2_q;
    s1_e_d      = a1_q;
    s1_f_d      = line_a_rd;
    s1_h_d      = h1_q;
    s1_approx_d = mode_approx;
    s1_abs_d    = mode_abs;
  end

  // Second stage: the Laplacian is (b+d)+(f+h)-4e, followed by saturation.
  // The mode bits are taken from stage 1, so each result uses the modes sampled with its own pixel.
  always_comb begin
    sum_bd  = mode_add(INT_W'(s1_b_q), INT_W'(s1_d_q), s1_approx_q);
    sum_fh  = mode_add(INT_W'(s1_f_q), INT_W'(s1_h_q), s1_approx_q);
    sum_all = mode_add(sum_bd, sum_fh, s1_approx_q);
    lap     = $signed(sum_all) - $signed(INT_W'({s1_e_q, 2'b00}));
    mag     = lap[INT_W-1] ? -lap : lap;

    result = '0;
    if (s1_abs_q) begin
      result = (mag > PIX_MAX) ? '1 : mag[DATA_W-1:0];
    end else if (!lap[INT_W-1]) begin
      result = (lap > PIX_MAX) ? '1 : lap[DATA_W-1:0];
    end

    out_valid_d = s1_valid_q;
    out_sol_d   = s1_valid_q && s1_sol_q;
    out_data_d  = s1_valid_q ? result : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      h1_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      b1_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_sol_q    <= 1'b0;
      s1_approx_q <= 1'b0;
      s1_abs_q    <= 1'b0;
      s1_b_q      <= '0;
      s1_d_q      <= '0;
      s1_e_q      <= '0;
      s1_f_q      <= '0;
      s1_h_q      <= '0;
      out_valid_q <= 1'b0;
      out_sol_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      h1_q        <= h1_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      b1_q        <= b1_d;
      s1_valid_q  <= s1_valid_d;
      s1_sol_q    <= s1_sol_d;
      s1_approx_q <= s1_approx_d;
      s1_abs_q    <= s1_abs_d;
      s1_b_q      <= s1_b_d;
      s1_d_q      <= s1_d_d;
      s1_e_q      <= s1_e_d;
      s1_f_q      <= s1_f_d;
      s1_h_q      <= s1_h_d;
      out_valid_q <= out_valid_d;
      out_sol_q   <= out_sol_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sol   = out_sol_q;

endmodule

// File: tb/tb_laplace_stream_filter.sv
// tb_laplace_stream_filter
// Bench for laplace_stream_filter with IMG_W=4, DATA_W=8 and APPROX_K=2.
// The reference model keeps the received frame as a 2-D array. For each interior
// pixel it computes the Laplacian straight from the neighbour arithmetic, then
// expects the result exactly two cycles after that pixel is accepted.
module tb_laplace_stream_filter;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int K  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          mode_approx = 1'b0;
  logic          mode_abs = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sol;

  laplace_stream_filter #(.DATA_W(DW), .IMG_W(IW), .APPROX_K(K)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_data     (in_data),
    .mode_approx (mode_approx),
    .mode_abs    (mode_abs),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sol     (out_sol)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int data;
    int sol;
  } exp_t;

  typedef struct {
    int    b, d, e, f, h;
    bit    ap, ab;
    int    exp;
    string name;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   edges = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  int   cap_data[$];
  int   cap_sol[$];
  int   seq_a[$];

  int   m_row = 0;
  int   m_col = 0;
  int   img [16][IW];
  int   frame_buf [16][IW];
  bit   ap_buf [16][IW];
  bit   ab_buf [16][IW];
  int   gap_mode = 0;
  bit   use_sof = 1'b1;
  vec_t vecs [12];

  always @(posedge clk) edges++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (edge %0d)", name, actual, expected, edges);
    end
  endtask

  // Sum of two values under the selected mode. In approximate mode the low K bits
  // are ORed and the rest is added.
  function automatic int refAdd(input int a, input int b, input bit ap);
    int m;
    m = (1 << K) - 1;
    if (!ap) return a + b;
    return ((((a >> K) + (b >> K)) << K) | ((a | b) & m));
  endfunction

  function automatic int refPixel(input int b, input int d, input int e, input int f,
                                  input int h, input bit ap, input bit ab);
    int l;
    int mx;
    mx = (1 << DW) - 1;
    l  = refAdd(refAdd(b, d, ap), refAdd(f, h, ap), ap) - 4 * e;
    if (ab) begin
      if (l < 0) l = -l;
      return (l > mx) ? mx : l;
    end
    if (l < 0) return 0;
    return (l > mx) ? mx : l;
  endfunction

  task automatic modelPixel(input bit s, input int d, input bit ap, input bit ab);
    int   r, c;
    exp_t e;
    r = s ? 0 : m_row;
    c = s ? 0 : m_col;
    if (r < 16) img[r][c] = d;
    if (r >= 2 && r < 16 && c >= 2) begin
      e.due  = edges + 1;
      e.data = refPixel(img[r-2][c-1], img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                        img[r][c-1], ap, ab);
      e.sol  = (c == 2) ? 1 : 0;
      exp_q.push_back(e);
    end
    if (c == IW - 1) begin
      m_col = 0;
      m_row = r + 1;
    end else begin
      m_col = c + 1;
      m_row = r;
    end
  endtask

  task automatic applyStimulus(input bit v, input bit s, input int d, input bit ap, input bit ab);
    in_valid    = v;
    in_sof      = s;
    in_data     = d[DW-1:0];
    mode_approx = ap;
    mode_abs    = ab;
    @(posedge clk);
    #1;
    if (v) modelPixel(s, d, ap, ab);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, int'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic sendPixels(input int start, input int count);
    for (int i = start; i < start + count; i++) begin
      if (gap_mode == 1) idle(1);
      if (gap_mode == 2) idle(int'($urandom_range(0, 2)));
      applyStimulus(1'b1, use_sof && (i == 0), frame_buf[i / IW][i % IW],
                    ap_buf[i / IW][i % IW], ab_buf[i / IW][i % IW]);
    end
  endtask

  task automatic fillFrame(input int kind, input int val, input bit ap, input bit ab);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < IW; c++) begin
        frame_buf[r][c] = (kind == 0) ? val : int'($urandom_range(0, 255));
        if (kind == 1 && $urandom_range(0, 5) == 0) frame_buf[r][c] = 255;
        ap_buf[r][c] = (kind == 2) ? 1'($urandom_range(0, 1)) : ap;
        ab_buf[r][c] = (kind == 2) ? 1'($urandom_range(0, 1)) : ab;
      end
    end
  endtask

  // Checks every cycle that out_valid is high only when an output is due, and
  // that out_data and out_sol match the model on those cycles.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (exp_q.size() > 0 && exp_q[0].due == edges) begin
        checkOutput("out_valid", int'(out_valid), 1);
        checkOutput("out_data", int'(out_data), exp_q[0].data);
        checkOutput("out_sol", int'(out_sol), exp_q[0].sol);
        void'(exp_q.pop_front());
      end else begin
        checkOutput("out_valid_idle", int'(out_valid), 0);
      end
      if (out_valid) begin
        cap_data.push_back(int'(out_data));
        cap_sol.push_back(int'(out_sol));
      end
    end
  end

  initial begin
    vecs[0]  = '{255, 255,   0, 255, 255, 1'b0, 1'b0, 255, "sat_pos"};
    vecs[1]  = '{  1,   1,   0,   1,   1, 1'b0, 1'b0,   4, "ones_exact"};
    vecs[2]  = '{  1,   1,   0,   1,   1, 1'b1, 1'b0,   1, "ones_approx"};
    vecs[3]  = '{  0,   0, 255,   0,   0, 1'b0, 1'b1, 255, "centre_abs"};
    vecs[4]  = '{  0,   0, 255,   0,   0, 1'b0, 1'b0,   0, "centre_clamp"};
    vecs[5]  = '{100, 100, 100, 100, 100, 1'b0, 1'b0,   0, "flat"};
    vecs[6]  = '{ 10,  20,  20,  30,  40, 1'b0, 1'b0,  20, "mixed_exact"};
    vecs[7]  = '{ 10,  20,  20,  30,  40, 1'b1, 1'b0,  18, "mixed_approx"};
    vecs[8]  = '{  3,   3,   1,   3,   3, 1'b1, 1'b1,   1, "neg_abs_approx"};
    vecs[9]  = '{  0,   0,  50,   0,   0, 1'b0, 1'b1, 200, "mag_200"};
    vecs[10] = '{200, 200,  10,   0,   0, 1'b0, 1'b0, 255, "sat_exact"};
    vecs[11] = '{  3,   3,   1,   3,   3, 1'b1, 1'b0,   0, "neg_clamp_approx"};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_data", int'(out_data), 0);
    checkOutput("reset_out_sol", int'(out_sol), 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Flat frame of 100: four zero outputs, out_sol on the first and third
    fillFrame(0, 100, 1'b0, 1'b0);
    cap_data.delete();
    cap_sol.delete();
    sendPixels(0, 4 * IW);
    idle(4);
    checkOutput("flat_count", cap_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_data.size()) begin
        checkOutput("flat_data", cap_data[i], 0);
        checkOutput("flat_sol", cap_sol[i], (i % 2 == 0) ? 1 : 0);
      end
    end

    // Table of single windows: window (2,2) of a 3-row frame
    foreach (vecs[v]) begin
      fillFrame(0, 0, vecs[v].ap, vecs[v].ab);
      frame_buf[0][1] = vecs[v].b;
      frame_buf[1][0] = vecs[v].d;
      frame_buf[1][1] = vecs[v].e;
      frame_buf[1][2] = vecs[v].f;
      frame_buf[2][1] = vecs[v].h;
      cap_data.delete();
      cap_sol.delete();
      sendPixels(0, 3 * IW);
      idle(4);
      checkOutput(vecs[v].name, (cap_data.size() > 0) ? cap_data[0] : -1, vecs[v].exp);
    end

    // A gap on every other cycle gives the same output sequence as a continuous stream
    fillFrame(1, 0, 1'b0, 1'b1);
    gap_mode = 0;
    cap_data.delete();
    sendPixels(0, 5 * IW);
    idle(4);
    seq_a = cap_data;
    checkOutput("cont_count", seq_a.size(), 6);
    gap_mode = 1;
    cap_data.delete();
    sendPixels(0, 5 * IW);
    idle(4);
    gap_mode = 0;
    checkOutput("gap_count", cap_data.size(), seq_a.size());
    for (int i = 0; i < seq_a.size() && i < cap_data.size(); i++)
      checkOutput("gap_vs_cont", cap_data[i], seq_a[i]);

    // in_sof again in the middle of row 2: no output until row 2 of the new frame
    fillFrame(1, 0, 1'b0, 1'b0);
    sendPixels(0, 2 * IW + 3);
    idle(3);
    cap_data.delete();
    fillFrame(1, 0, 1'b1, 1'b1);
    sendPixels(0, 2 * IW);
    idle(3);
    checkOutput("sof_suppress", cap_data.size(), 0);
    use_sof = 1'b0;
    sendPixels(2 * IW, 2 * IW);
    idle(4);
    use_sof = 1'b1;
    checkOutput("sof_resume", cap_data.size(), 4);

    // Random frames with random gaps and modes chosen for each pixel
    for (int f = 0; f < 4; f++) begin
      fillFrame(2, 0, 1'b0, 1'b0);
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < IW; c++)
          frame_buf[r][c] = int'($urandom_range(0, 255));
      gap_mode = 2;
      sendPixels(0, int'($urandom_range(6, 12)) * IW);
    end
    gap_mode = 0;
    idle(4);

    // Reset in the middle of a frame: the output drops at once, then the first pixel is (0,0)
    fillFrame(1, 0, 1'b0, 1'b1);
    sendPixels(0, 2 * IW + 4);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", int'(out_valid), 0);
    checkOutput("rst_mid_data", int'(out_data), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_row = 0;
    m_col = 0;
    cap_data.delete();
    use_sof = 1'b0;
    sendPixels(0, 3 * IW);
    use_sof = 1'b1;
    idle(4);
    checkOutput("post_rst_count", cap_data.size(), 2);
    checkOutput("pending_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/laplace_stream_filter.md
LAPLACE_STREAM_FILTER -- requirements
Module: laplace_stream_filter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 640, meaning pixels per line (minimum 3).
REQ-003 The block SHALL have parameter APPROX_K, default 2, meaning approximate low-bit count in approximate mode (0 to DATA_W-1).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port in_valid, input, 1 bit: in_data carries a pixel this cycle.
REQ-007 Port in_sof, input, 1 bit: start of frame, qualified by in_valid; marks pixel (0,0).
REQ-008 Port in_data, input, DATA_W bits: unsigned pixel in raster order.
REQ-009 Port mode_approx, input, 1 bit: 0 = exact neighbour sums, 1 = approximate sums.
REQ-010 Port mode_abs, input, 1 bit: 0 = clamp negatives to 0, 1 = output magnitude.
REQ-011 Port out_valid, output, 1 bit: out_data is valid this cycle.
REQ-012 Port out_data, output, DATA_W bits: saturated Laplacian of one interior pixel.
REQ-013 Port out_sol, output, 1 bit: marks the first output of each interior line.

Function
REQ-014 Column counter col (0..IMG_W-1) and row counter row SHALL advance on each accepted pixel; col wraps to 0 and row increments after IMG_W-1.
REQ-015 An accepted pixel with in_sof=1 SHALL be taken as (0,0), overriding the counters, including mid-frame.
REQ-016 Two line buffers of IMG_W entries SHALL hold rows row-1 and row-2, written at column col on every accepted pixel.
REQ-017 On pixel (r,c) with r>=2 and c>=2, the window SHALL be b=(r-2,c-1), d=(r-1,c-2), e=(r-1,c-1), f=(r-1,c), h=(r,c-1).
REQ-018 L SHALL be computed as (b+d)+(f+h)-4e in signed arithmetic at least DATA_W+4 bits wide, with no truncation.
REQ-019 When mode_approx=1, each of the three additions SHALL form its low APPROX_K bits as the bitwise OR of the operands, with no carry out of them; the upper bits SHALL be added exactly.
REQ-020 Output value: if mode_abs=0, max(0, min(L, 2^DATA_W-1)); if mode_abs=1, min(|L|, 2^DATA_W-1).
REQ-021 out_valid SHALL assert exactly 2 clk cycles after an in_valid cycle satisfying REQ-017, and at no other time; border pixels produce no output.
REQ-022 Mode inputs SHALL be sampled with the pixel; a mode change takes effect on the next pixel, with no corruption of in-flight results.
REQ-023 Gaps in in_valid SHALL stall the counters and line buffers; pipeline contents SHALL still drain at fixed latency.
REQ-024 out_sol SHALL equal 1 with out_valid for outputs whose source pixel had c=2.

Reset
REQ-025 With rst high, out_valid, out_sol and out_data SHALL be 0, col and row SHALL be 0, and all pipeline valid flags SHALL be 0.
REQ-026 Line buffer contents need not be cleared; no output SHALL depend on them before two lines are written after reset or in_sof.
REQ-027 Reset asserted mid-frame SHALL discard in-flight results; the first pixel after release SHALL be treated as (0,0).

Structure
REQ-028 A shared package SHALL hold the default DATA_W, IMG_W and APPROX_K values and the derived internal width DATA_W+4.
REQ-029 One sub-module, laplace_line_buffer (single-write, single-read, IMG_W deep, DATA_W wide), SHALL be instantiated twice.
REQ-030 Approximate/exact addition SHALL be one reusable function or sub-block, selected by mode_approx.

Verification (IMG_W=4, DATA_W=8, APPROX_K=2)
REQ-031 A flat frame of all 100, 4 rows, with mode_abs=0 SHALL give 4 outputs of 0, each 2 cycles after its source pixel, with out_sol on outputs 1 and 3.
REQ-032 All 0 except centre pixel (1,1)=255, with mode_abs=1, SHALL give out_data=255 for window (1,1); with mode_abs=0 it SHALL give 0.
REQ-033 b=d=f=h=255 and e=0 SHALL saturate to 255; b=d=f=h=1 and e=0 SHALL give 4 exact and 1 approximate (OR of low bits, no carries).
REQ-034 in_valid toggled every other cycle SHALL give the same out_data sequence as a continuous stream.
REQ-035 in_sof reasserted in the middle of row 2 SHALL suppress out_valid until row 2 of the new frame; rst pulsed mid-frame SHALL force out_valid=0 immediately.
